// File: rtl/jtkcpu_bus.sv
// rtl/jtkcpu_bus.sv - JTKCPU bus responder: clock enables, region decode and wait states
//
// Purpose:
//   Generates the CPU clock enables and runs one memory access per cen2.
//   The CPU address, write flag and write data are sampled in the START cycle
//   that follows a cen2. The access is decoded into RAM, IO or ROM and run to
//   completion. cen2 is held low until that access completes, so this block
//   is the only place where wait states are inserted.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   cen2, cen             CPU fast enable and slow enable (every second cen2)
//   cpu_addr/we/dout      CPU request, sampled in START
//   cpu_din               read data to the CPU, loaded on the completion edge
//   ext_addr/ext_dout     registered address and write data to the memories
//   ext_we                one-clk write strobe, in the first cs-high cycle
//   rom_cs/ram_cs/io_cs   region selects, one-hot or all low
//   rom_data/ram_data/io_data  read data from each region
//   rom_ok                SDRAM ROM data valid, only honoured during a ROM read

module jtkcpu_bus #(
  parameter int unsigned CEN_DIV = 2,
  parameter logic [15:0] RAM_END = 16'h3FFF,
  parameter logic [15:0] IO_END  = 16'h7FFF,
  parameter int unsigned IO_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        cen2,
  output logic        cen,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_dout,
  output logic        ext_we,
  output logic        rom_cs,
  output logic        ram_cs,
  output logic        io_cs,
  input  logic [7:0]  rom_data,
  input  logic [7:0]  ram_data,
  input  logic [7:0]  io_data,
  input  logic        rom_ok
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_ACC   = 2'd2;

  localparam logic [1:0] RG_RAM = 2'd0;
  localparam logic [1:0] RG_IO  = 2'd1;
  localparam logic [1:0] RG_ROM = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(CEN_DIV - 1);
  // RAM completes after two cs cycles (acc count 1); IO adds IO_WAIT more.
  localparam logic [3:0] RAM_LAST = 4'd1;
  localparam logic [3:0] IO_LAST  = 4'(IO_WAIT + 1);
  localparam logic [3:0] ACC_MAX  = 4'hF;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ph_q, ph_d;
  logic        done_q, done_d;
  logic [1:0]  region_q, region_d;
  logic        we_q, we_d;
  logic [3:0]  acc_q, acc_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic [7:0]  ext_dout_q, ext_dout_d;
  logic        ext_we_q, ext_we_d;
  logic        rom_cs_q, rom_cs_d;
  logic        ram_cs_q, ram_cs_d;
  logic        io_cs_q, io_cs_d;
  logic [7:0]  cpu_din_q, cpu_din_d;

  logic [1:0]  dec_region;
  logic [7:0]  rdata;
  logic        complete;
  logic        cen2_w;

  // The enable only fires once the phase counter has reached its last step
  // and no access is outstanding; while an access is pending cnt parks at
  // CNT_LAST so cen2 follows the completion edge by exactly one cycle.
  assign cen2_w = (cnt_q == CNT_LAST) && done_q;

  assign cen2     = cen2_w;
  assign cen      = cen2_w && ph_q;
  assign cpu_din  = cpu_din_q;
  assign ext_addr = ext_addr_q;
  assign ext_dout = ext_dout_q;
  assign ext_we   = ext_we_q;
  assign rom_cs   = rom_cs_q;
  assign ram_cs   = ram_cs_q;
  assign io_cs    = io_cs_q;

  // Inclusive decode: RAM_END is RAM, IO_END is IO, everything above is ROM.
  always_comb begin
    if (cpu_addr <= RAM_END) begin
      dec_region = RG_RAM;
    end else if (cpu_addr <= IO_END) begin
      dec_region = RG_IO;
    end else begin
      dec_region = RG_ROM;
    end
  end

  // Completion condition and read-data source for the access in flight.
  always_comb begin
    complete = 1'b0;
    rdata    = ram_data;
    case (region_q)
      RG_RAM: begin
        complete = (acc_q == RAM_LAST);
        rdata    = ram_data;
      end
      RG_IO: begin
        complete = (acc_q == IO_LAST);
        rdata    = io_data;
      end
      RG_ROM: begin
        // ROM writes are dropped but still take RAM time so the CPU sees a
        // uniform bus; rom_ok is only looked at for a real ROM read.
        complete = we_q ? (acc_q == RAM_LAST) : rom_ok;
        rdata    = rom_data;
      end
      default: begin
        complete = 1'b1;
        rdata    = ram_data;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    done_d     = done_q;
    region_d   = region_q;
    we_d       = we_q;
    acc_d      = acc_q;
    ext_addr_d = ext_addr_q;
    ext_dout_d = ext_dout_q;
    ext_we_d   = 1'b0;
    rom_cs_d   = rom_cs_q;
    ram_cs_d   = ram_cs_q;
    io_cs_d    = io_cs_q;
    cpu_din_d  = cpu_din_q;

    if (cen2_w) begin
      cnt_d = 4'd0;
      ph_d  = ~ph_q;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cen2_w) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        ext_addr_d = cpu_addr;
        ext_dout_d = cpu_dout;
        done_d     = 1'b0;
        region_d   = dec_region;
        we_d       = cpu_we;
        acc_d      = 4'd0;
        state_d    = ST_ACC;
        case (dec_region)
          RG_RAM: begin
            ram_cs_d = 1'b1;
            ext_we_d = cpu_we;
          end
          RG_IO: begin
            io_cs_d  = 1'b1;
            ext_we_d = cpu_we;
          end
          default: begin
            rom_cs_d = ~cpu_we;
          end
        endcase
      end

      ST_ACC: begin
        if (acc_q != ACC_MAX) begin
          acc_d = acc_q + 4'd1;
        end
        if (complete) begin
          rom_cs_d = 1'b0;
          ram_cs_d = 1'b0;
          io_cs_d  = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
          if (!we_q) begin
            cpu_din_d = rdata;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset lands in START so the reset-time CPU address is served first,
  // with done low so no cen2 can fire ahead of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_START;
      cnt_q      <= 4'd0;
      ph_q       <= 1'b0;
      done_q     <= 1'b0;
      region_q   <= RG_RAM;
      we_q       <= 1'b0;
      acc_q      <= 4'd0;
      ext_addr_q <= 16'h0000;
      ext_dout_q <= 8'h00;
      ext_we_q   <= 1'b0;
      rom_cs_q   <= 1'b0;
      ram_cs_q   <= 1'b0;
      io_cs_q    <= 1'b0;
      cpu_din_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      done_q     <= done_d;
      region_q   <= region_d;
      we_q       <= we_d;
      acc_q      <= acc_d;
      ext_addr_q <= ext_addr_d;
      ext_dout_q <= ext_dout_d;
      ext_we_q   <= ext_we_d;
      rom_cs_q   <= rom_cs_d;
      ram_cs_q   <= ram_cs_d;
      io_cs_q    <= io_cs_d;
      cpu_din_q  <= cpu_din_d;
    end
  end

endmodule

// File: doc/jtkcpu_bus.md
# jtkcpu_bus

Bus responder for the JTKCPU memory controller: it owns the CPU's clock enables, samples the CPU's `addr`/`we`/`dout` after each `cen2`, and decodes the access into ROM, RAM or IO. It runs the access to completion, returning read data on `din` and stretching `cen2`/`cen` while an access is pending. It sits between the CPU core and the game's SDRAM ROM port, work RAM and IO registers, and is the single place where wait states are inserted.

## Interface
Parameters:
- `CEN_DIV`, 2: clk cycles per `cen2` when no wait is pending. Legal range is 2 to 15.
- `RAM_END`, 16'h3FFF: RAM occupies 0 to `RAM_END`.
- `IO_END`, 16'h7FFF: IO occupies `RAM_END`+1 to `IO_END`. ROM occupies `IO_END`+1 to FFFF.
- `IO_WAIT`, 1: extra clk cycles an IO access holds `io_cs`. Legal range is 0 to 7.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `cen2` out 1: CPU fast enable, to memctrl `cen2`.
- `cen` out 1: CPU slow enable, high on every second `cen2`.
- `cpu_addr` in 16: CPU address.
- `cpu_we` in 1: CPU write request.
- `cpu_dout` in 8: CPU write data.
- `cpu_din` out 8: read data to the CPU.
- `ext_addr` out 16: registered address to memories.
- `ext_dout` out 8: registered write data.
- `ext_we` out 1: write strobe, one clk wide.
- `rom_cs`, `ram_cs`, `io_cs` out 1: region selects, at most one high at a time.
- `rom_data`, `ram_data`, `io_data` in 8: read data from each region.
- `rom_ok` in 1: ROM data valid, from SDRAM. May arrive any number of cycles after `rom_cs`.

## Operation
- Phase counter `cnt` runs 0..`CEN_DIV`-1.
- `cen2` = (`cnt`==`CEN_DIV`-1) && `done`.
- `cnt` wraps to 0 on `cen2`. It holds at `CEN_DIV`-1 while `!done`.
- `cen` = `cen2` && `ph`. `ph` toggles on every `cen2`.
- FSM states:
  - IDLE: wait for `cen2`, then go to START.
  - START: one cycle, in which the CPU address is stable.
    - Register `ext_addr` from `cpu_addr` and `ext_dout` from `cpu_dout`.
    - Clear `done`.
    - Decode the region and go to ACC.
    - At the START edge, assert the region's cs; call the first cs-high cycle C.
  - ACC, completion rule per region:
    - RAM read: sample `ram_data` at the end of C+1.
    - IO read: sample `io_data` at the end of C+1+`IO_WAIT`.
    - ROM read: sample `rom_data` at the end of the first cycle ≥C in which `rom_ok`=1.
  - Completion edge, for all regions:
    - Load `cpu_din` (reads only).
    - Drop cs.
    - Set `done`.
    - Return to IDLE.
- Writes (`cpu_we`=1 in START):
  - RAM/IO: `ext_we`=1 in cycle C only. `ram_cs`/`io_cs` follow the read timing. `cpu_din` is unchanged.
  - ROM region: `rom_cs` is never asserted and `ext_we` stays 0. Completes at the end of C+1, as RAM does.
- Decode boundaries are inclusive: `RAM_END` is RAM, `RAM_END`+1 is IO, `IO_END`+1 is ROM.
- `rom_ok` high outside ACC-ROM is ignored. It cannot complete the next access early.

## Timing
- Reset values:
  - `cen2`, `cen`, `ext_we`, all cs: 0.
  - `cpu_din`, `ext_addr`, `ext_dout`: 0.
  - `cnt`, `ph`: 0.
  - `done`: 0.
- Leaving reset goes straight to START, so the first access covers the reset-time `cpu_addr` and no `cen2` fires before it completes.
- With `CEN_DIV`=2 and `cen2` in cycle t:
  - START is t+1.
  - C is t+2.
  - RAM read or any write completes at the end of t+3; next `cen2` is at t+4.
  - IO completes at the end of t+3+`IO_WAIT`.
  - ROM completes at end of cycle (first `rom_ok` cycle ≥ t+2); next `cen2` is one cycle later.
- Larger `CEN_DIV`: `cen2` period = max(`CEN_DIV`, access time + 2).
- `cpu_din` is stable from the completion edge until the next completion edge.
- Reset during ACC: on the reset edge, cs and `ext_we` drop and the pending access is discarded. After release, behaviour is identical to power-up.

## Test plan
- RAM read, `CEN_DIV`=2, `cpu_addr`=0x1234, `ram_data`=0x5A → `ram_cs` high 2 clks; `cpu_din`=0x5A; `cen2` spacing 4 clks; `cen` on alternate `cen2`.
- ROM read at 0x8000, `rom_ok` raised 5 clks after `rom_cs`, `rom_data`=0xC3 → `cen2` held low throughout the wait; `cpu_din`=0xC3; `cen2` one clk after the `rom_ok` cycle; `rom_cs` low after it.
- IO write at 0x4000 with `cpu_dout`=0x77, `IO_WAIT`=3 → `ext_we` is a single clk with `ext_addr`=0x4000 and `ext_dout`=0x77; `io_cs` is 5 clks wide; `cpu_din` unchanged.
- Boundary decode at 0x3FFF, 0x4000, 0x7FFF, 0x8000 → selects are RAM, IO, IO, ROM respectively; never two cs high at once.
- Write to ROM region at 0xFFFE → `rom_cs`=0 and `ext_we`=0; completes in RAM time.
- `rst_n` low mid ROM wait → cs drops on that edge; all outputs take reset values; after release the first access starts with no `cen2` before it; a stale `rom_ok` pulse during IDLE is ignored.
